// File: rtl/crc_host_pkg.sv
// crc_host_pkg: shared constants for the CRC accelerator AHB-Lite host interface.
// Holds the register offsets, the transfer size codes, the AHB encodings, the bus
// FSM state encoding, the CR bit positions and the write-lane alignment helper.
package crc_host_pkg;

    // Byte offsets of the CRC register set
    localparam logic [4:0] DR_OFF   = 5'h00;
    localparam logic [4:0] IDR_OFF  = 5'h04;
    localparam logic [4:0] CR_OFF   = 5'h08;
    localparam logic [4:0] INIT_OFF = 5'h0C;
    localparam logic [4:0] POL_OFF  = 5'h10;

    // Transfer size codes (hsize[1:0]); also used on size_out
    localparam logic [1:0] BYTE      = 2'b00;
    localparam logic [1:0] HALF_WORD = 2'b01;
    localparam logic [1:0] WORD      = 2'b10;

    // AHB transfer type and response encodings
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    localparam logic       HRESP_OKAY    = 1'b0;
    localparam logic       HRESP_ERROR   = 1'b1;

    // CRC_CR bit positions
    localparam int CR_RESET_BIT  = 0;
    localparam int CR_POLY_LSB   = 3;
    localparam int CR_REVIN_LSB  = 5;
    localparam int CR_REVOUT_BIT = 7;

    // Bus FSM states
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DATA     = 3'd1,
        STALL_WR = 3'd2,
        STALL_RD = 3'd3,
        ERR_1    = 3'd4,
        ERR_2    = 3'd5
    } host_state_e;

    // Write data always comes from the low lanes; narrower sizes are zero-extended.
    function automatic logic [31:0] lane_align(input logic [1:0] size, input logic [31:0] data);
        case (size)
            BYTE:      return {24'h0, data[7:0]};
            HALF_WORD: return {16'h0, data[15:0]};
            default:   return data;
        endcase
    endfunction

endpackage

// File: rtl/crc_host_regs.sv
// crc_host_regs: CRC register file (CRC_IDR, CRC_CR fields, CRC_INIT, CRC_POL).
// Decodes the single-cycle write strobe from the bus FSM into register updates,
// raises reset_chain for a CR write with RESET set, and provides the read mux.
// Sub-word writes only touch the addressed low bytes.
module crc_host_regs
    import crc_host_pkg::*;
#(
    parameter logic [31:0] INIT_RST = 32'hFFFF_FFFF,
    parameter logic [31:0] POL_RST  = 32'h04C1_1DB7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  off,
    input  logic [1:0]  size,
    input  logic [31:0] wdata,
    input  logic [31:0] crc_out,
    input  logic        reset_pending,
    output logic [31:0] rdata,
    output logic [31:0] crc_init,
    output logic [31:0] crc_poly,
    output logic [1:0]  poly_size,
    output logic [1:0]  rev_in,
    output logic        rev_out,
    output logic        reset_chain
);

    logic [31:0] init_q, init_d;
    logic [31:0] poly_q, poly_d;
    logic [7:0]  idr_q, idr_d;
    logic [1:0]  psz_q, psz_d;
    logic [1:0]  rin_q, rin_d;
    logic        rout_q, rout_d;
    logic [31:0] mask;

    // Byte-lane mask of the bytes touched by a write of the given size
    always_comb begin
        case (size)
            BYTE:      mask = 32'h0000_00FF;
            HALF_WORD: mask = 32'h0000_FFFF;
            default:   mask = 32'hFFFF_FFFF;
        endcase
    end

    // Next-state decode of the write strobe
    always_comb begin
        init_d = init_q;
        poly_d = poly_q;
        idr_d  = idr_q;
        psz_d  = psz_q;
        rin_d  = rin_q;
        rout_d = rout_q;
        if (we) begin
            case (off)
                IDR_OFF: idr_d = wdata[7:0];
                CR_OFF: begin
                    psz_d  = wdata[CR_POLY_LSB +: 2];
                    rin_d  = wdata[CR_REVIN_LSB +: 2];
                    rout_d = wdata[CR_REVOUT_BIT];
                end
                INIT_OFF: init_d = (init_q & ~mask) | (wdata & mask);
                POL_OFF:  poly_d = (poly_q & ~mask) | (wdata & mask);
                default: ;
            endcase
        end
    end

    // Register state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_q <= INIT_RST;
            poly_q <= POL_RST;
            idr_q  <= 8'h00;
            psz_q  <= 2'b00;
            rin_q  <= 2'b00;
            rout_q <= 1'b0;
        end else begin
            init_q <= init_d;
            poly_q <= poly_d;
            idr_q  <= idr_d;
            psz_q  <= psz_d;
            rin_q  <= rin_d;
            rout_q <= rout_d;
        end
    end

    // Read mux; CR bit0 reflects the control unit's pending reset, not a stored bit
    always_comb begin
        case (off)
            DR_OFF:   rdata = crc_out;
            IDR_OFF:  rdata = {24'h0, idr_q};
            CR_OFF:   rdata = {24'h0, rout_q, rin_q, psz_q, 2'b00, reset_pending};
            INIT_OFF: rdata = init_q;
            POL_OFF:  rdata = poly_q;
            default:  rdata = 32'h0;
        endcase
    end

    assign reset_chain = we && (off == CR_OFF) && wdata[CR_RESET_BIT];
    assign crc_init    = init_q;
    assign crc_poly    = poly_q;
    assign poly_size   = psz_q;
    assign rev_in      = rin_q;
    assign rev_out     = rout_q;

endmodule

// File: rtl/crc_host_interface.sv
// crc_host_interface: AHB-Lite slave front end of the CRC accelerator.
// Captures the address phase, runs the data phase through a small bus FSM that
// inserts wait states on buffer_full (DR writes) and read_wait (DR reads), and turns
// DR writes into one-cycle write/size_out/data_out pushes.
// Optional feature macro CRC_ERROR_RESP_EN: when defined, invalid accesses get a
// two-cycle ERROR response; otherwise they complete OKAY with no effect.
module crc_host_interface
    import crc_host_pkg::*;
#(
    parameter int          ADDR_W   = 5,
    parameter logic [31:0] INIT_RST = 32'hFFFF_FFFF,
    parameter logic [31:0] POL_RST  = 32'h04C1_1DB7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hsel,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    input  logic [31:0]       hwdata,
    input  logic              hready,
    output logic [31:0]       hrdata,
    output logic              hreadyout,
    output logic              hresp,
    input  logic [31:0]       crc_out,
    input  logic              buffer_full,
    input  logic              read_wait,
    input  logic              reset_pending,
    output logic              write,
    output logic [1:0]        size_out,
    output logic [31:0]       data_out,
    output logic              reset_chain,
    output logic [31:0]       crc_init,
    output logic [31:0]       crc_poly,
    output logic [1:0]        poly_size,
    output logic [1:0]        rev_in,
    output logic              rev_out
);

    host_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic              write_q;
    logic [2:0]        size_q;
    logic              cap;
    logic              acc_ok;
    logic              is_dr;
    logic              reg_we;
    logic [31:0]       off;
    logic [31:0]       reg_rdata;
    logic [31:0]       push_data;

    assign cap       = hsel && hready && ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));
    assign off       = 32'(addr_q);
    assign is_dr     = (off == 32'(DR_OFF));
    assign push_data = lane_align(size_q[1:0], hwdata);

    // Legal access: byte/half/word, word aligned, inside the map, CRC_IDR byte only
    assign acc_ok = !size_q[2] && (size_q[1:0] != 2'b11)
                 && (off[1:0] == 2'b00)
                 && (off <= 32'(POL_OFF))
                 && !((off == 32'(IDR_OFF)) && (size_q[1:0] != BYTE));

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Address-phase capture, only when a new data phase actually starts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= 3'b000;
        end else if (cap && (state_d == DATA)) begin
            addr_q  <= haddr;
            write_q <= hwrite;
            size_q  <= hsize;
        end
    end

    // Next state and data-phase outputs; a completing cycle chains into the next access
    always_comb begin
        state_d   = state_q;
        hreadyout = 1'b1;
        hresp     = HRESP_OKAY;
        write     = 1'b0;
        size_out  = 2'b00;
        data_out  = 32'h0;
        hrdata    = 32'h0;
        reg_we    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cap) state_d = DATA;
            end
            DATA: begin
                if (!acc_ok) begin
`ifdef CRC_ERROR_RESP_EN
                    hreadyout = 1'b0;
                    state_d   = ERR_1;
`else
                    state_d   = cap ? DATA : IDLE;
`endif
                end else if (write_q && is_dr) begin
                    if (buffer_full) begin
                        hreadyout = 1'b0;
                        state_d   = STALL_WR;
                    end else begin
                        write    = 1'b1;
                        size_out = size_q[1:0];
                        data_out = push_data;
                        state_d  = cap ? DATA : IDLE;
                    end
                end else if (!write_q && is_dr && read_wait) begin
                    hreadyout = 1'b0;
                    state_d   = STALL_RD;
                end else begin
                    reg_we  = write_q;
                    hrdata  = write_q ? 32'h0 : reg_rdata;
                    state_d = cap ? DATA : IDLE;
                end
            end
            STALL_WR: begin
                if (buffer_full) begin
                    hreadyout = 1'b0;
                end else begin
                    write    = 1'b1;
                    size_out = size_q[1:0];
                    data_out = push_data;
                    state_d  = cap ? DATA : IDLE;
                end
            end
            STALL_RD: begin
                if (read_wait) begin
                    hreadyout = 1'b0;
                end else begin
                    hrdata  = crc_out;
                    state_d = cap ? DATA : IDLE;
                end
            end
`ifdef CRC_ERROR_RESP_EN
            ERR_1: begin
                hresp     = HRESP_ERROR;
                hreadyout = 1'b0;
                state_d   = ERR_2;
            end
            ERR_2: begin
                hresp   = HRESP_ERROR;
                state_d = cap ? DATA : IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    crc_host_regs #(
        .INIT_RST (INIT_RST),
        .POL_RST  (POL_RST)
    ) u_regs (
        .clk           (clk),
        .rst           (rst),
        .we            (reg_we),
        .off           (off[4:0]),
        .size          (size_q[1:0]),
        .wdata         (hwdata),
        .crc_out       (crc_out),
        .reset_pending (reset_pending),
        .rdata         (reg_rdata),
        .crc_init      (crc_init),
        .crc_poly      (crc_poly),
        .poly_size     (poly_size),
        .rev_in        (rev_in),
        .rev_out       (rev_out),
        .reset_chain   (reset_chain)
    );

endmodule

// File: tb/tb_crc_host_interface.sv
// Testbench for crc_host_interface: directed vector table, hand-written multi-cycle
// sequences (pipelined pushes, CR reset, reset during a stalled write) and random
// accesses checked against a register-map model.
`timescale 1ns/1ps
module tb_crc_host_interface;
    import crc_host_pkg::*;

`ifdef CRC_ERROR_RESP_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hsel = 1'b0;
    logic [4:0]  haddr = '0;
    logic [1:0]  htrans = HTRANS_IDLE;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = '0;
    logic [31:0] hwdata = '0;
    logic        hready;
    logic [31:0] hrdata;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] crc_out = '0;
    logic        buffer_full = 1'b0;
    logic        read_wait = 1'b0;
    logic        reset_pending = 1'b0;
    logic        write;
    logic [1:0]  size_out;
    logic [31:0] data_out;
    logic        reset_chain;
    logic [31:0] crc_init;
    logic [31:0] crc_poly;
    logic [1:0]  poly_size;
    logic [1:0]  rev_in;
    logic        rev_out;

    always #5 clk = ~clk;
    assign hready = hreadyout;

    crc_host_interface dut (
        .clk(clk), .rst(rst), .hsel(hsel), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready),
        .hrdata(hrdata), .hreadyout(hreadyout), .hresp(hresp), .crc_out(crc_out),
        .buffer_full(buffer_full), .read_wait(read_wait), .reset_pending(reset_pending),
        .write(write), .size_out(size_out), .data_out(data_out), .reset_chain(reset_chain),
        .crc_init(crc_init), .crc_poly(crc_poly), .poly_size(poly_size),
        .rev_in(rev_in), .rev_out(rev_out)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        int          waits;
        int          nwrite;
        int          nrc;
        int          resp_cnt;
        int          overlap;
        logic [31:0] dout;
        logic [1:0]  szout;
        logic [31:0] rdata;
        logic        resp_last;
        logic        timeout;
    } res_t;

    typedef struct {
        logic [4:0]  a;
        logic        wr;
        logic [2:0]  sz;
        logic [31:0] wd;
        int          nst;
        logic [31:0] crc;
        logic        rp;
        int          ew;
        int          enw;
        logic [31:0] edout;
        logic [1:0]  esz;
        logic [31:0] erd;
        int          eresp;
        int          enrc;
    } vec_t;

    // ---------------- reference model of the register map ----------------
    logic [31:0] m_init, m_pol;
    logic [7:0]  m_idr;
    logic [1:0]  m_psz, m_rin;
    logic        m_rout;

    task automatic m_reset();
        m_init = 32'hFFFF_FFFF; m_pol = 32'h04C1_1DB7; m_idr = 8'h0;
        m_psz = 2'b00; m_rin = 2'b00; m_rout = 1'b0;
    endtask

    function automatic bit m_valid(input logic [4:0] a, input logic [2:0] sz);
        return (sz <= 3'd2) && (a % 4 == 0) && (a <= 5'd16) && !(a == 5'd4 && sz != 3'd0);
    endfunction

    // Replace the low (1 << sz) bytes of old with those of wd
    function automatic logic [31:0] m_merge(input logic [31:0] old, input logic [31:0] wd, input logic [2:0] sz);
        logic [31:0] r = old;
        for (int b = 0; b < (1 << sz); b++) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    task automatic predict(input logic [4:0] a, input logic wr, input logic [2:0] sz, input logic [31:0] wd,
                           input int nst, input logic [31:0] crc, input logic rp, output res_t e);
        e = '{default: 0};
        if (!m_valid(a, sz)) begin
            if (ERR_EN) begin e.waits = 2; e.resp_cnt = 2; e.resp_last = 1'b1; end
        end else if (a == 5'd0) begin
            e.waits = nst;
            if (wr) begin e.nwrite = 1; e.dout = m_merge(32'h0, wd, sz); e.szout = sz[1:0]; end
            else e.rdata = crc;
        end else if (wr) begin
            case (a)
                5'd4:  m_idr = wd[7:0];
                5'd8:  begin m_psz = wd[4:3]; m_rin = wd[6:5]; m_rout = wd[7]; e.nrc = int'(wd[0]); end
                5'd12: m_init = m_merge(m_init, wd, sz);
                default: m_pol = m_merge(m_pol, wd, sz);
            endcase
        end else begin
            case (a)
                5'd4:  e.rdata = {24'h0, m_idr};
                5'd8:  e.rdata = {24'h0, m_rout, m_rin, m_psz, 2'b00, rp};
                5'd12: e.rdata = m_init;
                default: e.rdata = m_pol;
            endcase
        end
    endtask

    // ---------------- one non-pipelined transfer ----------------
    // The stall input matching the direction is held for the first nst data-phase cycles.
    task automatic run_access(input logic [4:0] a, input logic wr, input logic [2:0] sz, input logic [31:0] wd,
                              input int nst, output res_t r);
        int k = 0;
        bit done = 0;
        r = '{default: 0};
        @(posedge clk); #1;
        hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = a; hwrite = wr; hsize = sz; hwdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = HTRANS_IDLE; haddr = 5'($urandom); hwrite = 1'b0; hsize = 3'd0; hwdata = wd;
        while (!done && k < 20) begin
            buffer_full = wr && (k < nst);
            read_wait   = !wr && (k < nst);
            @(negedge clk);
            if (write) begin r.nwrite++; r.dout = data_out; r.szout = size_out; end
            if (reset_chain) r.nrc++;
            if ((write || reset_chain) && hresp) r.overlap++;
            if (write && !hreadyout) r.overlap++;
            if (!hreadyout && hrdata != 32'h0) r.overlap++;
            if (hresp) r.resp_cnt++;
            if (hreadyout) begin done = 1; r.rdata = hrdata; r.resp_last = hresp; end
            else r.waits++;
            @(posedge clk); #1;
            k++;
        end
        r.timeout = !done;
        buffer_full = 1'b0; read_wait = 1'b0;
    endtask

    task automatic cmp_res(input string tag, input res_t r, input res_t e);
        check({tag, ".timeout"}, 32'(r.timeout), 32'(0));
        check({tag, ".waits"},   32'(r.waits),   32'(e.waits));
        check({tag, ".nwrite"},  32'(r.nwrite),  32'(e.nwrite));
        check({tag, ".data_out"}, r.dout, e.dout);
        check({tag, ".size_out"}, 32'(r.szout), 32'(e.szout));
        check({tag, ".hrdata"},  r.rdata, e.rdata);
        check({tag, ".hresp_cycles"}, 32'(r.resp_cnt), 32'(e.resp_cnt));
        check({tag, ".hresp_last"}, 32'(r.resp_last), 32'(e.resp_last));
        check({tag, ".reset_chain"}, 32'(r.nrc), 32'(e.nrc));
        check({tag, ".overlap"}, 32'(r.overlap), 32'(0));
    endtask

    vec_t tv[16];
    res_t r, e;
    int   pulses;

    initial begin
        // ---------------- reset state ----------------
        m_reset();
        @(negedge clk); @(negedge clk);
        check("rst.hreadyout", 32'(hreadyout), 32'(1));
        check("rst.hresp", 32'(hresp), 32'(0));
        check("rst.write", 32'(write), 32'(0));
        check("rst.reset_chain", 32'(reset_chain), 32'(0));
        check("rst.size_out", 32'(size_out), 32'(0));
        check("rst.data_out", data_out, 32'h0);
        check("rst.hrdata", hrdata, 32'h0);
        check("rst.crc_init", crc_init, 32'hFFFF_FFFF);
        check("rst.crc_poly", crc_poly, 32'h04C1_1DB7);
        check("rst.cr_fields", 32'({rev_out, rev_in, poly_size}), 32'(0));
        @(posedge clk); #1; rst = 1'b0;

        // ---------------- directed vector table ----------------
        //          a      wr  sz    wd            nst crc           rp  ew             enw edout         esz    erd           eresp          enrc
        tv[0]  = '{5'h00, 1, 3'd2, 32'h12345678, 0, 32'h0,        0,  0,             1, 32'h12345678, 2'b10, 32'h0,        0,             0};
        tv[1]  = '{5'h00, 1, 3'd0, 32'hFFFFFFAB, 3, 32'h0,        0,  3,             1, 32'h000000AB, 2'b00, 32'h0,        0,             0};
        tv[2]  = '{5'h00, 0, 3'd2, 32'h0,        2, 32'hCBF43926, 0,  2,             0, 32'h0,        2'b00, 32'hCBF43926, 0,             0};
        tv[3]  = '{5'h08, 1, 3'd2, 32'h00000009, 0, 32'h0,        0,  0,             0, 32'h0,        2'b00, 32'h0,        0,             1};
        tv[4]  = '{5'h08, 0, 3'd2, 32'h0,        0, 32'h0,        1,  0,             0, 32'h0,        2'b00, 32'h00000009, 0,             0};
        tv[5]  = '{5'h08, 0, 3'd0, 32'h0,        0, 32'h0,        0,  0,             0, 32'h0,        2'b00, 32'h00000008, 0,             0};
        tv[6]  = '{5'h14, 1, 3'd1, 32'h0000BEEF, 0, 32'h0,        0,  ERR_EN ? 2 : 0, 0, 32'h0,       2'b00, 32'h0,        ERR_EN ? 2 : 0, 0};
        tv[7]  = '{5'h0C, 1, 3'd1, 32'h1234A5A5, 0, 32'h0,        0,  0,             0, 32'h0,        2'b00, 32'h0,        0,             0};
        tv[8]  = '{5'h0C, 0, 3'd2, 32'h0,        0, 32'h0,        0,  0,             0, 32'h0,        2'b00, 32'hFFFFA5A5, 0,             0};
        tv[9]  = '{5'h04, 1, 3'd1, 32'h00000077, 0, 32'h0,        0,  ERR_EN ? 2 : 0, 0, 32'h0,       2'b00, 32'h0,        ERR_EN ? 2 : 0, 0};
        tv[10] = '{5'h04, 1, 3'd0, 32'h1234565C, 0, 32'h0,        0,  0,             0, 32'h0,        2'b00, 32'h0,        0,             0};
        tv[11] = '{5'h04, 0, 3'd0, 32'h0,        0, 32'h0,        0,  0,             0, 32'h0,        2'b00, 32'h0000005C, 0,             0};
        tv[12] = '{5'h02, 1, 3'd2, 32'h55555555, 0, 32'h0,        0,  ERR_EN ? 2 : 0, 0, 32'h0,       2'b00, 32'h0,        ERR_EN ? 2 : 0, 0};
        tv[13] = '{5'h00, 0, 3'd3, 32'h0,        1, 32'h77777777, 0,  ERR_EN ? 2 : 0, 0, 32'h0,       2'b00, 32'h0,        ERR_EN ? 2 : 0, 0};
        tv[14] = '{5'h10, 0, 3'd2, 32'h0,        0, 32'h0,        0,  0,             0, 32'h0,        2'b00, 32'h04C11DB7, 0,             0};
        tv[15] = '{5'h00, 1, 3'd1, 32'hFFFF1234, 1, 32'h0,        0,  1,             1, 32'h00001234, 2'b01, 32'h0,        0,             0};

        for (int i = 0; i < 16; i++) begin
            crc_out = tv[i].crc; reset_pending = tv[i].rp;
            e = '{default: 0};
            e.waits = tv[i].ew; e.nwrite = tv[i].enw; e.dout = tv[i].edout; e.szout = tv[i].esz;
            e.rdata = tv[i].erd; e.resp_cnt = tv[i].eresp; e.resp_last = (tv[i].eresp != 0);
            e.nrc = tv[i].enrc;
            run_access(tv[i].a, tv[i].wr, tv[i].sz, tv[i].wd, tv[i].nst, r);
            cmp_res($sformatf("vec%0d", i), r, e);
        end
        check("vec.poly_size", 32'(poly_size), 32'(1));
        check("vec.rev_in", 32'(rev_in), 32'(0));
        check("vec.rev_out", 32'(rev_out), 32'(0));
        check("vec.crc_init", crc_init, 32'hFFFF_A5A5);

        // ---------------- CR fields without RESET ----------------
        run_access(5'h08, 1'b1, 3'd0, 32'h0000_00E8, 0, r);
        check("cr.reset_chain", 32'(r.nrc), 32'(0));
        check("cr.fields", 32'({rev_out, rev_in, poly_size}), 32'b1_11_01);

        // ---------------- back-to-back pipelined DR pushes ----------------
        @(posedge clk); #1;
        hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = 5'h00; hwrite = 1'b1; hsize = 3'd2;
        @(posedge clk); #1;
        hsize = 3'd0; hwdata = 32'h1111_1111;
        @(negedge clk);
        check("pipe.first.write", 32'(write), 32'(1));
        check("pipe.first.data_out", data_out, 32'h1111_1111);
        check("pipe.first.size_out", 32'(size_out), 32'(2));
        @(posedge clk); #1;
        hsel = 1'b0; htrans = HTRANS_IDLE; hwrite = 1'b0; hwdata = 32'h2222_22CD;
        @(negedge clk);
        check("pipe.second.write", 32'(write), 32'(1));
        check("pipe.second.data_out", data_out, 32'h0000_00CD);
        check("pipe.second.size_out", 32'(size_out), 32'(0));
        @(negedge clk);
        check("pipe.idle.write", 32'(write), 32'(0));

        // ---------------- reset during a stalled write ----------------
        run_access(5'h10, 1'b1, 3'd2, 32'h1111_1111, 0, r);
        run_access(5'h0C, 1'b1, 3'd2, 32'h2222_2222, 0, r);
        check("stall.pre.crc_poly", crc_poly, 32'h1111_1111);
        @(posedge clk); #1;
        hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = 5'h00; hwrite = 1'b1; hsize = 3'd0;
        buffer_full = 1'b1;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = HTRANS_IDLE; hwrite = 1'b0; hwdata = 32'h0000_00AB;
        @(posedge clk); #1;
        @(negedge clk);
        check("stall.hreadyout", 32'(hreadyout), 32'(0));
        #2 rst = 1'b1;
        #1;
        check("stall.rst.hreadyout", 32'(hreadyout), 32'(1));
        check("stall.rst.write", 32'(write), 32'(0));
        check("stall.rst.crc_poly", crc_poly, 32'h04C1_1DB7);
        check("stall.rst.crc_init", crc_init, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        rst = 1'b0; buffer_full = 1'b0;
        m_reset();
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (write) pulses++;
        end
        check("stall.dropped.write_pulses", 32'(pulses), 32'(0));

        // ---------------- randomized accesses against the model ----------------
        for (int i = 0; i < 150; i++) begin
            logic [4:0]  a;
            logic        wr;
            logic [2:0]  sz;
            logic [31:0] wd;
            int          nst;
            case ($urandom_range(0, 7))
                0, 6, 7: a = 5'h00;
                1: a = 5'h04;
                2: a = 5'h08;
                3: a = 5'h0C;
                4: a = 5'h10;
                default: a = 5'($urandom_range(0, 31));
            endcase
            wr  = 1'($urandom);
            sz  = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
            wd  = $urandom;
            nst = $urandom_range(0, 3);
            crc_out = $urandom;
            reset_pending = 1'($urandom);
            predict(a, wr, sz, wd, nst, crc_out, reset_pending, e);
            run_access(a, wr, sz, wd, nst, r);
            cmp_res($sformatf("rnd%0d", i), r, e);
            check($sformatf("rnd%0d.crc_init", i), crc_init, m_init);
            check($sformatf("rnd%0d.crc_poly", i), crc_poly, m_pol);
            check($sformatf("rnd%0d.cr_fields", i), 32'({rev_out, rev_in, poly_size}), 32'({m_rout, m_rin, m_psz}));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so the run always terminates
    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/crc_host_interface.md
Name: crc_host_interface

Overview:
- AHB-Lite slave front end of the CRC accelerator.
- Decodes bus accesses into the CRC register set and converts data-register writes into single-cycle write/size/data pulses for the CRC control unit and input buffer.
- Inserts wait states while the control unit reports buffer_full (writes) or read_wait (result reads).
- Returns the CRC result and configuration on reads.

Parameters:
- ADDR_W, 5, number of haddr bits decoded; upper bits ignored because hsel qualifies the access.
- INIT_RST, 32'hFFFF_FFFF, reset value of CRC_INIT.
- POL_RST, 32'h04C1_1DB7, reset value of CRC_POL.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- hsel  in  1  slave select.
- haddr  in  ADDR_W  byte address.
- htrans  in  2  AHB transfer type; bit1 marks NONSEQ/SEQ.
- hwrite  in  1  1=write.
- hsize  in  3  000 byte, 001 half, 010 word.
- hwdata  in  32  write data.
- hready  in  1  bus-wide ready.
- hrdata  out  32  read data.
- hreadyout  out  1  slave ready.
- hresp  out  1  0 OKAY, 1 ERROR.
- crc_out  in  32  current CRC result.
- buffer_full  in  1  from control unit.
- read_wait  in  1  from control unit.
- reset_pending  in  1  from control unit.
- write  out  1  one-cycle data push.
- size_out  out  2  size code of the pushed data.
- data_out  out  32  pushed data, lane-0 aligned.
- reset_chain  out  1  one-cycle chained-CRC reset request.
- crc_init  out  32  CRC_INIT register.
- crc_poly  out  32  CRC_POL register.
- poly_size  out  2  CR[4:3].
- rev_in  out  2  CR[6:5].
- rev_out  out  1  CR[7].

Behaviour:
- Register map (word offsets):
  - 0x00 CRC_DR: write pushes data; read returns crc_out.
  - 0x04 CRC_IDR: 8-bit scratch register.
  - 0x08 CRC_CR: bit0 RESET is write-1 and reads reset_pending; bits [7:3] are fields.
  - 0x0C CRC_INIT.
  - 0x10 CRC_POL.
- Address phase is captured when hsel && htrans[1] && hready. The registered address, hwrite and hsize are held for the data phase.
- FSM states: IDLE, DATA, STALL_WR, STALL_RD, ERR_1, ERR_2.
- IDLE → DATA on a captured access; otherwise stay in IDLE.
- DATA:
  - Valid DR write with buffer_full=0: assert write, size_out=hsize[1:0] and data_out=hwdata in the same cycle; hreadyout=1; return to IDLE, or stay in DATA if a new access is captured.
  - DR write with buffer_full=1: hreadyout=0, go to STALL_WR.
  - DR read with read_wait=1: hreadyout=0, go to STALL_RD.
  - Any other valid access completes in zero wait states.
- STALL_WR: hold hreadyout=0. Leave in the first cycle where buffer_full=0; that cycle pushes with the captured hwdata (AHB holds hwdata during wait states) and drives hreadyout=1.
- STALL_RD: hold hreadyout=0. Leave when read_wait=0; hrdata=crc_out in that cycle and hreadyout=1.
- Invalid accesses: hsize ≥ 011, haddr[1:0] ≠ 0, offset > 0x10, or CRC_IDR wider than byte. Handling is governed by the optional feature below.
- Write data is taken from lanes starting at lane 0:
  - byte → hwdata[7:0], zero-extended;
  - half → hwdata[15:0], zero-extended;
  - word → full 32 bits.
- Register writes below word width update only the addressed low bytes.
- CR write with bit0=1: reset_chain pulses for exactly one cycle at data-phase completion, concurrently with any field update.
- A CR write while reset_pending=1 still pulses reset_chain; the control unit arbitrates.
- Outputs are at most one access deep; there is no write posting.
- write and reset_chain are never asserted together with hresp=1.
- hrdata is 0 outside read data-phase completion.
- Reset, including mid-stall:
  - FSM=IDLE; hreadyout=1, hresp=0, write=0, reset_chain=0;
  - size_out=00, data_out=0, hrdata=0;
  - crc_init=INIT_RST, crc_poly=POL_RST;
  - CR fields=0 (poly_size=00 means 32-bit), CRC_IDR=0.
  - Any stalled write is dropped.

Optional Feature:
- CRC_ERROR_RESP_EN defined: invalid access goes DATA → ERR_1 → ERR_2.
  - ERR_1: hresp=1, hreadyout=0.
  - ERR_2: hresp=1, hreadyout=1.
  - No register update, no write pulse.
- CRC_ERROR_RESP_EN undefined: invalid access completes OKAY in zero wait states; writes ignored, reads return 0; ERR states are not built.

Decomposition:
- Package crc_host_pkg holds:
  - offsets DR_OFF, IDR_OFF, CR_OFF, INIT_OFF, POL_OFF;
  - size codes BYTE=2'b00, HALF_WORD=2'b01, WORD=2'b10;
  - HTRANS/HRESP encodings;
  - FSM state encodings;
  - CR bit positions.
- Sub-module crc_host_regs: register file with write-strobe decode and read mux. The bus FSM stays in crc_host_interface.

Test Plan:
- Word write 0x12345678 to 0x00 with buffer_full=0 → one-cycle write, size_out=10, data_out=0x12345678, hreadyout=1, zero waits.
- Byte write 0xAB to 0x00 with buffer_full=1 for 3 cycles → hreadyout=0 for 3 cycles; write pulses with data_out=0x000000AB, size_out=00 in the 4th cycle.
- Read 0x00 with read_wait=1 for 2 cycles and crc_out=0xCBF43926 → 2 waits, then hrdata=0xCBF43926 with hreadyout=1.
- Write 0x09 to CR → reset_chain pulses once, poly_size=01, rev_in=00, rev_out=0; CR readback bit0 equals reset_pending.
- Half write to 0x14 with CRC_ERROR_RESP_EN defined → hresp=1/hreadyout=0, then hresp=1/hreadyout=1, no write; with the macro undefined → OKAY, no waits.
- Assert rst during STALL_WR → hreadyout=1, write never pulses, crc_poly=0x04C11DB7, crc_init=0xFFFFFFFF.
